// File: rtl/rr_grant_encoder_pkg.sv
// Shared types and sizes for the 8-way round-robin grant encoder.
// Combinational content only; no latency or backpressure of its own.
package rr_grant_encoder_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/rr_grant_encoder_if.sv
// Request/release inputs and registered grant outputs of the round-robin encoder.
// master drives req/done and observes the grant; slave is the arbiter side.
interface rr_grant_encoder_if;

  logic [rr_grant_encoder_pkg::N_REQ-1:0] req;
  logic                                   done;
  logic                                   grant_valid;
  logic [rr_grant_encoder_pkg::IDX_W-1:0] grant_idx;
  logic                                   timeout;

  modport master (
    output req, done,
    input  grant_valid, grant_idx, timeout
  );

  modport slave (
    input  req, done,
    output grant_valid, grant_idx, timeout
  );

endinterface

// File: rtl/rr_grant_encoder_pick8.sv
// Finds the first set request at or after ptr with wrap; purely combinational.
// No state, so no latency and no backpressure.
module rr_pick8
  import rr_grant_encoder_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  logic [N_REQ-1:0] rot;
  logic [IDX_W-1:0] off;

  // Rotate so the ptr position lands in bit 0, then search LSB-first.
  assign rot = N_REQ'({req, req} >> ptr);

  always_comb begin
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
  end

  assign idx = off + ptr;
  assign any = |req;

endmodule

// File: rtl/rr_grant_encoder.sv
// Round-robin 8-way grant encoder; grant appears 1 cycle after req is sampled.
// No backpressure: the owner releases via done or dropping req, else the hold timeout revokes it.
module rr_grant_encoder
  import rr_grant_encoder_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  rr_grant_encoder_if.slave bus
);

  localparam bit               TO_EN     = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(TO_EN ? MAX_HOLD - 1 : 0);

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [CNT_W-1:0] hold_cnt;
  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;
  logic             owner_req;
  logic             expired;
  logic             release_now;

  rr_pick8 u_pick (
    .req (bus.req),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign owner_req   = bus.req[bus.grant_idx];
  assign expired     = TO_EN && (hold_cnt == HOLD_LAST);
  assign release_now = bus.done || !owner_req || expired;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      ptr             <= '0;
      hold_cnt        <= '0;
      bus.grant_valid <= 1'b0;
      bus.grant_idx   <= '0;
      bus.timeout     <= 1'b0;
    end else begin
      bus.timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            bus.grant_idx   <= pick_idx;
            bus.grant_valid <= 1'b1;
            hold_cnt        <= '0;
            state           <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (release_now) begin
            // Returning to IDLE forces one idle cycle before any regrant.
            bus.grant_valid <= 1'b0;
            ptr             <= bus.grant_idx + IDX_W'(1);
            bus.timeout     <= expired && !bus.done && owner_req;
            state           <= ST_IDLE;
          end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
